// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - write/read port bundle for sync_fifo
interface sync_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic                   i_wp_en;
    logic [WIDTH-1:0]       i_wp_data;
    logic                   o_wp_full;
    logic                   o_wp_af;
    logic                   o_wp_overflow;
    logic                   i_rp_en;
    logic [WIDTH-1:0]       o_rp_data;
    logic                   o_rp_empty;
    logic                   o_rp_ae;
    logic                   o_rp_underflow;
    logic [$clog2(DEPTH):0] o_count;

    modport master (
        output i_wp_en, i_wp_data, i_rp_en,
        input  o_wp_full, o_wp_af, o_wp_overflow,
               o_rp_data, o_rp_empty, o_rp_ae, o_rp_underflow, o_count
    );

    modport slave (
        input  i_wp_en, i_wp_data, i_rp_en,
        output o_wp_full, o_wp_af, o_wp_overflow,
               o_rp_data, o_rp_empty, o_rp_ae, o_rp_underflow, o_count
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with threshold flags and optional FWFT read port
module sync_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 8,
    parameter int AF_THRESHOLD = DEPTH - 2,
    parameter int AE_THRESHOLD = 1,
    parameter int FWFT         = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    sync_fifo_if.slave  f
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "sync_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_THRESHOLD < 1 || AF_THRESHOLD > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo: AF_THRESHOLD out of range");
    end
    if (AE_THRESHOLD < 0 || AE_THRESHOLD > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo: AE_THRESHOLD out of range");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok;
    logic             overflow;
    logic             underflow;

    // Flags come only from the registered count, so they lag an operation by one cycle.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_ok = f.i_rp_en && !empty;
    assign wr_ok = f.i_wp_en && (!full || rd_ok);

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= f.i_wp_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= f.i_wp_en && full && !rd_ok;
            underflow <= f.i_rp_en && empty;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign f.o_rp_data = mem[rd_ptr];
    end else begin : g_reg_read
        logic [WIDTH-1:0] rd_data;

        // Reset clears the output register so stale pre-reset words never appear.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                rd_data <= '0;
            end else if (rd_ok) begin
                rd_data <= mem[rd_ptr];
            end
        end

        assign f.o_rp_data = rd_data;
    end

    assign f.o_wp_full      = full;
    assign f.o_wp_af        = (count >= CW'(AF_THRESHOLD));
    assign f.o_wp_overflow  = overflow;
    assign f.o_rp_empty     = empty;
    assign f.o_rp_ae        = (count <= CW'(AE_THRESHOLD));
    assign f.o_rp_underflow = underflow;
    assign f.o_count        = count;
endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo (registered and FWFT read ports)
module tb_sync_fifo;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sync_fifo_if #(.WIDTH(8), .DEPTH(4)) fa ();
    sync_fifo_if #(.WIDTH(8), .DEPTH(4)) fb ();

    sync_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESHOLD(3), .AE_THRESHOLD(1), .FWFT(0)) dut_reg (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .f       (fa)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESHOLD(3), .AE_THRESHOLD(1), .FWFT(1)) dut_fwft (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .f       (fb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] fill [4];
        checks   = 0;
        failures = 0;
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
        rst_n = 1'b0;
        fa.i_wp_en = 1'b0; fa.i_wp_data = '0; fa.i_rp_en = 1'b0;
        fb.i_wp_en = 1'b0; fb.i_wp_data = '0; fb.i_rp_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_count", fa.o_count, 0);
        chk("rst_empty", fa.o_rp_empty, 1);
        chk("rst_full", fa.o_wp_full, 0);
        chk("rst_ae", fa.o_rp_ae, 1);
        chk("rst_af", fa.o_wp_af, 0);
        chk("rst_ovf", fa.o_wp_overflow, 0);
        chk("rst_udf", fa.o_rp_underflow, 0);
        chk("rst_data", fa.o_rp_data, 0);

        // Fill to full, flags after each write
        fa.i_wp_en = 1'b1; fa.i_wp_data = 8'h11; tick();
        chk("w1_count", fa.o_count, 1); chk("w1_ae", fa.o_rp_ae, 1); chk("w1_af", fa.o_wp_af, 0);
        fa.i_wp_data = 8'h22; tick();
        chk("w2_count", fa.o_count, 2); chk("w2_ae", fa.o_rp_ae, 0);
        fa.i_wp_data = 8'h33; tick();
        chk("w3_count", fa.o_count, 3); chk("w3_af", fa.o_wp_af, 1); chk("w3_full", fa.o_wp_full, 0);
        fa.i_wp_data = 8'h44; tick();
        chk("w4_count", fa.o_count, 4); chk("w4_full", fa.o_wp_full, 1);

        // Rejected write when full
        fa.i_wp_data = 8'h55; tick();
        chk("ovf_pulse", fa.o_wp_overflow, 1); chk("ovf_count", fa.o_count, 4);
        fa.i_wp_en = 1'b0; tick();
        chk("ovf_clear", fa.o_wp_overflow, 0);

        fa.i_rp_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain1_data", fa.o_rp_data, fill[i]);
        end
        fa.i_rp_en = 1'b0;
        chk("drain1_empty", fa.o_rp_empty, 1);
        chk("drain1_count", fa.o_count, 0);

        // Simultaneous read/write while full
        fa.i_wp_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fa.i_wp_data = fill[i];
            tick();
        end
        fa.i_wp_data = 8'h66; fa.i_rp_en = 1'b1; tick();
        chk("rwfull_count", fa.o_count, 4);
        chk("rwfull_full", fa.o_wp_full, 1);
        chk("rwfull_data", fa.o_rp_data, 8'h11);
        chk("rwfull_ovf", fa.o_wp_overflow, 0);
        fa.i_wp_en = 1'b0;
        tick(); chk("drain2_a", fa.o_rp_data, 8'h22);
        tick(); chk("drain2_b", fa.o_rp_data, 8'h33);
        tick(); chk("drain2_c", fa.o_rp_data, 8'h44);
        tick(); chk("drain2_d", fa.o_rp_data, 8'h66);
        chk("drain2_empty", fa.o_rp_empty, 1);

        // Simultaneous read/write while empty: no bypass
        fa.i_wp_en = 1'b1; fa.i_wp_data = 8'h77; tick();
        chk("rwempty_udf", fa.o_rp_underflow, 1);
        chk("rwempty_count", fa.o_count, 1);
        chk("rwempty_data", fa.o_rp_data, 8'h66);
        fa.i_wp_en = 1'b0; fa.i_rp_en = 1'b0; tick();
        chk("udf_clear", fa.o_rp_underflow, 0);
        fa.i_rp_en = 1'b1; tick();
        chk("rd77_data", fa.o_rp_data, 8'h77);
        chk("rd77_empty", fa.o_rp_empty, 1);
        fa.i_rp_en = 1'b0;

        // First-word-fall-through port
        fb.i_wp_en = 1'b1; fb.i_wp_data = 8'hA5; tick();
        fb.i_wp_en = 1'b0;
        chk("fwft_data", fb.o_rp_data, 8'hA5);
        chk("fwft_empty", fb.o_rp_empty, 0);
        fb.i_rp_en = 1'b1; tick();
        fb.i_rp_en = 1'b0;
        chk("fwft_pop_empty", fb.o_rp_empty, 1);
        fb.i_wp_en = 1'b1; fb.i_wp_data = 8'h5A; tick();
        fb.i_wp_data = 8'hC3; tick();
        fb.i_wp_en = 1'b0;
        chk("fwft_head1", fb.o_rp_data, 8'h5A);
        fb.i_rp_en = 1'b1; tick();
        fb.i_rp_en = 1'b0;
        chk("fwft_head2", fb.o_rp_data, 8'hC3);
        chk("fwft_count", fb.o_count, 1);

        // Reset mid-operation overrides a concurrent write
        fa.i_wp_en = 1'b1;
        fa.i_wp_data = 8'hA1; tick();
        fa.i_wp_data = 8'hA2; tick();
        fa.i_wp_data = 8'hA3; tick();
        chk("prerst_count", fa.o_count, 3);
        fa.i_wp_data = 8'hEE; rst_n = 1'b0; tick();
        rst_n = 1'b1; fa.i_wp_en = 1'b0;
        chk("midrst_count", fa.o_count, 0);
        chk("midrst_empty", fa.o_rp_empty, 1);
        chk("midrst_ae", fa.o_rp_ae, 1);
        chk("midrst_data", fa.o_rp_data, 0);
        chk("midrst_fwft_empty", fb.o_rp_empty, 1);
        fa.i_rp_en = 1'b1; tick();
        fa.i_rp_en = 1'b0;
        chk("postrst_udf", fa.o_rp_underflow, 1);
        chk("postrst_data", fa.o_rp_data, 0);

        for (int i = 0; i < 10; i++) begin
            fa.i_wp_en = 1'b1; fa.i_wp_data = 8'(8'h30 + i); tick();
            fa.i_wp_en = 1'b0; fa.i_rp_en = 1'b1; tick();
            fa.i_rp_en = 1'b0;
            chk("wrap_data", fa.o_rp_data, 8'(8'h30 + i));
            chk("wrap_empty", fa.o_rp_empty, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 8: entry count; power of 2 and >=2, else elaboration-time fatal error.
REQ-003 SHALL have parameter AF_THRESHOLD, default DEPTH-2: almost-full level; 1..DEPTH, else fatal.
REQ-004 SHALL have parameter AE_THRESHOLD, default 1: almost-empty level; 0..DEPTH-1, else fatal.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered read (1-cycle latency), 1 = first-word-fall-through.
REQ-006 SHALL have port i_clk  input  1: single clock; all state updates on rising edge.
REQ-007 SHALL have port i_rst_n  input  1: reset, synchronous, active-low.
REQ-008 SHALL have port i_wp_en  input  1: write request.
REQ-009 SHALL have port i_wp_data  input  WIDTH: write data, sampled with i_wp_en.
REQ-010 SHALL have port o_wp_full  output  1: count == DEPTH.
REQ-011 SHALL have port o_wp_af  output  1: count >= AF_THRESHOLD.
REQ-012 SHALL have port o_wp_overflow  output  1: one-cycle pulse flagging a rejected write.
REQ-013 SHALL have port i_rp_en  input  1: read (pop) request.
REQ-014 SHALL have port o_rp_data  output  WIDTH: read data.
REQ-015 SHALL have port o_rp_empty  output  1: count == 0.
REQ-016 SHALL have port o_rp_ae  output  1: count <= AE_THRESHOLD.
REQ-017 SHALL have port o_rp_underflow  output  1: one-cycle pulse flagging a rejected read.
REQ-018 SHALL have port o_count  output  $clog2(DEPTH)+1: current stored-entry count, 0..DEPTH.

Function
REQ-019 Storage SHALL be a DEPTH x WIDTH register array with $clog2(DEPTH)-bit read/write pointers; each pointer wraps DEPTH-1 -> 0.
REQ-020 Write accepted SHALL mean i_wp_en && (!o_wp_full || read accepted same cycle); accepted word stored at write pointer, pointer +1.
REQ-021 Read accepted SHALL mean i_rp_en && !o_rp_empty; read pointer +1.
REQ-022 o_count SHALL be a register: +1 on write-only, -1 on read-only, unchanged on both or neither; never exceeds DEPTH nor goes below 0.
REQ-023 o_wp_full, o_rp_empty, o_wp_af, o_rp_ae SHALL be decoded from registered o_count only, reflecting an operation in the following cycle.
REQ-024 Simultaneous read+write when full: both accepted, count stays DEPTH, full stays 1.
REQ-025 Simultaneous read+write when empty: write accepted, read rejected (underflow pulses), count becomes 1; no bypass of write data to the read port.
REQ-026 FWFT=0: on read accepted, o_rp_data SHALL present the popped word one cycle later; otherwise hold its last value.
REQ-027 FWFT=1: o_rp_data SHALL combinationally present the entry at read pointer; defined only when o_rp_empty=0; i_rp_en acknowledges/pops it.
REQ-028 o_wp_overflow SHALL be a registered pulse, 1 in the cycle after a write is rejected (i_wp_en && full && no read accepted); stored data unchanged.
REQ-029 o_rp_underflow SHALL be a registered pulse, 1 in the cycle after i_rp_en while empty; pointers and o_rp_data unchanged.
REQ-030 Data order SHALL be strict first-in first-out across any number of pointer wraps.

Reset
REQ-031 When i_rst_n=0 at a rising edge, reset SHALL override i_wp_en/i_rp_en that cycle, including mid-operation.
REQ-032 After reset: pointers=0, o_count=0, o_rp_empty=1, o_wp_full=0, o_rp_ae=1, o_wp_af=0, overflow=underflow=0, o_rp_data=0 when FWFT=0.
REQ-033 Storage array contents SHALL NOT be reset; previously stored data SHALL never be readable after reset.

Verification (WIDTH=8, DEPTH=4, AF_THRESHOLD=3, AE_THRESHOLD=1, FWFT=0 unless stated)
REQ-034 Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; af rises after 3rd write, full after 4th; ae falls after 2nd write.
REQ-035 Full, write 0x55 alone -> overflow pulses 1 cycle, count stays 4; then four reads return 0x11,0x22,0x33,0x44 each one cycle after its i_rp_en; empty=1.
REQ-036 Full, read and write 0x66 together -> count stays 4, full stays 1; drain order 0x22,0x33,0x44,0x66.
REQ-037 Empty, read and write 0x77 together -> underflow pulses, count=1; next read returns 0x77.
REQ-038 FWFT=1: write 0xA5 into empty -> o_rp_data=0xA5 the cycle after the write, before any i_rp_en; pop -> empty=1.
REQ-039 Write 3 words, assert i_rst_n=0 for 1 cycle alongside i_wp_en=1 -> count=0, empty=1, ae=1, o_rp_data=0; ten write/read pairs afterwards stay in order across wrap.
